// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default busy durations.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdOp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdState_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Codes 0-3 are the ops that occupy the unit for several cycles.
  function automatic logic isMulDiv(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational arithmetic for the MDU: 64-bit products and
// quotient/remainder pairs, plus a validity flag for the result.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        ok
);

  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic               signedDiv;
  logic        [31:0] magA;
  logic        [31:0] magB;
  logic        [31:0] safeB;
  logic        [31:0] uQuot;
  logic        [31:0] uRem;
  logic        [31:0] sQuot;
  logic        [31:0] sRem;

  assign sProd = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign uProd = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division runs on magnitudes; 0x80000000 / -1 then falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  assign signedDiv = (md_op == OP_DIV);
  assign magA  = (signedDiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign magB  = (signedDiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
  assign safeB = (magB == 32'd0) ? 32'd1 : magB;
  assign uQuot = magA / safeB;
  assign uRem  = magA % safeB;
  assign sQuot = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uQuot) : uQuot;
  assign sRem  = rs_val[31] ? (32'd0 - uRem) : uRem;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    ok     = 1'b0;
    case (md_op)
      OP_MULT: begin
        res_hi = sProd[63:32];
        res_lo = sProd[31:0];
        ok     = 1'b1;
      end
      OP_MULTU: begin
        res_hi = uProd[63:32];
        res_lo = uProd[31:0];
        ok     = 1'b1;
      end
      OP_DIV: begin
        res_hi = sRem;
        res_lo = sQuot;
        ok     = (rt_val != 32'd0);
      end
      OP_DIVU: begin
        res_hi = uRem;
        res_lo = uQuot;
        ok     = (rt_val != 32'd0);
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        ok     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO and sequences multi-cycle MULT/DIV ops, holding
// the precomputed result until the busy period expires.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdState_e    state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] p_hi_q;
  logic [31:0] p_lo_q;
  logic        p_ok_q;

  logic [31:0] resHi;
  logic [31:0] resLo;
  logic        resOk;

  mdu_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .res_hi (resHi),
    .res_lo (resLo),
    .ok     (resOk)
  );

  assign cnt_d = cnt_q - 4'd1;

  // The result is captured at issue; the busy period only models latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_ok_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (isMulDiv(md_op)) begin
              p_hi_q  <= resHi;
              p_lo_q  <= resLo;
              p_ok_q  <= resOk;
              cnt_q   <= md_op[1] ? DIV_CNT : MULT_CNT;
              state_q <= ST_RUN;
            end else if (md_op == OP_MTHI) begin
              hi_q <= rs_val;
            end else if (md_op == OP_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_d;
          if (cnt_q == 4'd1) begin
            if (p_ok_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = d_md_use & (busy | (start & isMulDiv(md_op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed results, busy durations, stall
// behaviour, ignored starts and reset abandonment.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one op at a negedge, optionally injects a MULT start on busy
  // cycle injectAt, and checks latency, stall, held and final HI/LO.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic useD, input int injectAt, input int expCycles,
                               input logic [31:0] preHi, input logic [31:0] preLo,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    int cycles;
    start    = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    d_md_use = useD;
    #1;
    checkOutput({tag, ".issueStall"}, {31'd0, stall}, {31'd0, useD & (op <= 3'd3)});
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      if (cycles == 1) begin
        checkOutput({tag, ".holdHi"}, hi, preHi);
        checkOutput({tag, ".holdLo"}, lo, preLo);
      end
      if (useD) checkOutput({tag, ".busyStall"}, {31'd0, stall}, 32'd1);
      if (cycles == injectAt) begin
        start  = 1'b1;
        md_op  = OP_MULT;
        rs_val = 32'hFFFF_FFFF;
        rt_val = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput({tag, ".cycles"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, ".hi"}, hi, expHi);
    checkOutput({tag, ".lo"}, lo, expLo);
    checkOutput({tag, ".doneStall"}, {31'd0, stall}, 32'd0);
    d_md_use = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".staysIdle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    d_md_use = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.busy", {31'd0, busy}, 32'd0);
    checkOutput("rst.stall", {31'd0, stall}, 32'd0);
    checkOutput("rst.hi", hi, 32'd0);
    checkOutput("rst.lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 5,
                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    applyStimulus("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 5,
                  32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
    applyStimulus("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 10,
                  32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divu", OP_DIVU, 32'd7, 32'd2, 1'b0, 0, 10,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
    applyStimulus("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 10,
                  32'd1, 32'd3, 32'd0, 32'h8000_0000);
    applyStimulus("mthi", OP_MTHI, 32'h11, 32'd0, 1'b0, 0, 0,
                  32'd0, 32'h8000_0000, 32'h11, 32'h8000_0000);
    applyStimulus("mtlo", OP_MTLO, 32'h22, 32'd0, 1'b0, 0, 0,
                  32'h11, 32'h8000_0000, 32'h11, 32'h22);
    applyStimulus("divZero", OP_DIV, 32'd100, 32'd0, 1'b0, 0, 10,
                  32'h11, 32'h22, 32'h11, 32'h22);
    applyStimulus("stallMult", OP_MULT, 32'd6, 32'd7, 1'b1, 0, 5,
                  32'h11, 32'h22, 32'd0, 32'd42);
    applyStimulus("startBusy", OP_MULT, 32'd5, 32'd5, 1'b0, 2, 5,
                  32'd0, 32'd42, 32'd0, 32'd25);
    applyStimulus("startLast", OP_MULTU, 32'd3, 32'd4, 1'b0, 5, 5,
                  32'd0, 32'd25, 32'd0, 32'd12);
    applyStimulus("reserved", 3'd6, 32'hDEAD_BEEF, 32'd9, 1'b1, 0, 0,
                  32'd0, 32'd12, 32'd0, 32'd12);
    applyStimulus("mthi2", OP_MTHI, 32'h55, 32'd0, 1'b0, 0, 0,
                  32'd0, 32'd12, 32'h55, 32'd12);

    // Reset during the fourth busy cycle of a DIV must drop its result.
    start  = 1'b1;
    md_op  = OP_DIV;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rstRun.busy1", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstRun.busy", {31'd0, busy}, 32'd0);
    checkOutput("rstRun.hi", hi, 32'd0);
    checkOutput("rstRun.lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("rstRun.lateBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstRun.lateHi", hi, 32'd0);
    checkOutput("rstRun.lateLo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage issues an MDU op this cycle.
REQ-006 md_op  input  3  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
REQ-007 rs_val  input  32  operand A (dividend / multiplicand / MT source).
REQ-008 rt_val  input  32  operand B (divisor / multiplier).
REQ-009 d_md_use  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
REQ-010 busy  output  1  multi-cycle op in progress.
REQ-011 stall  output  1  pipeline freeze request to hazard logic.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 FSM states: IDLE, RUN; a 4-bit down-counter cnt; pending result registers p_hi/p_lo and a commit flag p_ok.
REQ-015 In IDLE, start with op 0-3 SHALL latch the result into p_hi/p_lo, load cnt with MULT_CYCLES or DIV_CYCLES, and move to RUN.
REQ-016 In RUN, cnt SHALL decrement each cycle; at the edge where cnt==1, hi/lo SHALL take p_hi/p_lo if p_ok, and the FSM SHALL return to IDLE.
REQ-017 busy SHALL equal (state==RUN); a start sampled at edge t SHALL give busy=1 for exactly N cycles (t+1..t+N), with new hi/lo visible from the cycle busy falls.
REQ-018 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-019 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-021 Divisor zero (DIV/DIVU) SHALL clear p_ok: full busy period runs, hi/lo unchanged.
REQ-022 MTHI/MTLO with start in IDLE SHALL write rs_val to hi/lo at the next edge, no RUN entry, busy stays 0.
REQ-023 start while busy=1, or with reserved op, SHALL be ignored (no state change); hazard logic guarantees it does not occur legally.
REQ-024 stall SHALL be combinational: d_md_use & (busy | (start & md_op<=3)).
REQ-025 hi/lo SHALL be readable combinationally at all times; during RUN they hold pre-op values.
REQ-026 start coincident with the final RUN cycle (cnt==1) SHALL be ignored; a new op is accepted only in IDLE.

Reset
REQ-027 reset=1 at an edge SHALL force state=IDLE, cnt=0, busy=0, hi=0, lo=0, p_hi=0, p_lo=0, p_ok=0, regardless of operation in progress.
REQ-028 reset mid-RUN SHALL abandon the pending result; no hi/lo commit occurs.
REQ-029 reset SHALL take priority over start in the same cycle.

Structure
REQ-030 Shared package mdu_pkg SHALL hold md_op encodings, state encodings and default cycle counts.
REQ-031 One combinational sub-module mdu_arith SHALL compute {res_hi,res_lo,ok} from md_op, rs_val, rt_val; mdu_ctrl holds all state.

Verification
REQ-032 MULT rs=0xFFFFFFFE(-2), rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 DIV rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-034 hi=0x11, lo=0x22 preloaded by MTHI/MTLO; DIV by 0 -> busy 10 cycles, hi=0x11, lo=0x22 after.
REQ-035 MULT issued, d_md_use=1 from next cycle -> stall=1 in issue cycle and all 5 busy cycles, 0 once busy falls.
REQ-036 DIV issued, reset pulsed on 4th busy cycle -> next cycle busy=0, hi=lo=0, no later commit.
REQ-037 start with MULT while busy=1 -> ignored; original op completes at its scheduled edge with its own result.
